// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with mid-bit sampling, parity/framing/break
// detection and a show-ahead receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [15:0]          cpb,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_brk,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 rx_overrun,
    input  logic                 ovr_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 3;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_s_d, strobe, pbit, perr, ovr;
    logic                   ferr, brk, push, pop, full, empty, wr;
    logic [15:0]            cnt, half;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   data;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW:0]            wp, rp;

    assign rx_s  = sync[SYNC_STAGES-1];
    assign half  = cpb >> 1;
    assign ferr  = !rx_s;
    // pbit is cleared while idle, so a disabled parity bit counts as 0 for break
    assign brk   = ferr && data == '0 && !pbit;
    assign push  = strobe && state == STOP;
    assign empty = wp == rp;
    assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign pop   = rx_valid && rx_ready;
    assign wr    = push && (!full || pop);

    always_comb begin
        state_n = state;
        strobe  = state == START ? (cnt == half - 16'd1) : (state != IDLE && cnt == cpb - 16'd1);
        case (state)
            IDLE:    state_n = (rx_s_d && !rx_s) ? START : IDLE;
            START:   state_n = strobe ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_n = (strobe && idx == IW'(DATA_BITS - 1)) ? (parity_en ? PARITY : STOP) : DATA;
            PARITY:  state_n = strobe ? STOP : PARITY;
            STOP:    state_n = strobe ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '1;
            rx_s_d <= 1'b1;
            cnt    <= '0;
            idx    <= '0;
            data   <= '0;
            pbit   <= 1'b0;
            perr   <= 1'b0;
            wp     <= '0;
            rp     <= '0;
            ovr    <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], rx};
            rx_s_d <= rx_s;
            cnt    <= (state == IDLE || strobe) ? '0 : cnt + 16'd1;
            if (state == IDLE) begin
                idx  <= '0;
                pbit <= 1'b0;
                perr <= 1'b0;
            end
            if (state == DATA && strobe) begin
                data[idx] <= rx_s;
                idx       <= idx + IW'(1);
            end
            if (state == PARITY && strobe) begin
                pbit <= rx_s;
                perr <= ^data ^ rx_s ^ parity_odd;
            end
            if (wr)  wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
            if (push && full && !pop) ovr <= 1'b1;
            else if (ovr_clr)         ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= {brk, ferr, perr, data};

    assign {rx_brk, rx_ferr, rx_perr, rx_data} = empty ? '0 : mem[rp[AW-1:0]];
    assign rx_valid   = !empty;
    assign rx_busy    = state != IDLE;
    assign rx_overrun = ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomised frames against a frame-level reference model,
// expected entries queued at stimulus time and compared by an independent monitor.
module tb_uart_rx_fifo;
    localparam int DB = 8;

    logic          clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic          parity_en = 1'b0, parity_odd = 1'b0, rx_ready = 1'b0, ovr_clr = 1'b0;
    logic [15:0]   cpb = 16'd16;
    logic [DB-1:0] rx_data;
    logic          rx_perr, rx_ferr, rx_brk, rx_valid, rx_busy, rx_overrun;
    int            checks = 0, errors = 0, vcount = 0;
    bit            rnd_ready = 1'b0;
    logic [DB+2:0] exp_q[$];
    logic [DB+2:0] e_m, a_m;

    uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .cpb(cpb), .parity_en(parity_en), .parity_odd(parity_odd),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_brk(rx_brk),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
        .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // A correct transmitter sends parity bit = ^data ^ odd; anything else is a parity error.
    function automatic logic [DB+2:0] model(input logic [DB-1:0] d, input bit pen, odd, pbit, stop);
        bit perr, brk;
        perr = pen && (pbit != ((^d) ^ odd));
        brk  = !stop && d == '0 && !(pen && pbit);
        return {brk, !stop, perr, d};
    endfunction

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) begin
            if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit pen, odd, pbit, stop, store, input int gap);
        parity_en  = pen;
        parity_odd = odd;
        if (store) exp_q.push_back(model(d, pen, odd, pbit, stop));
        drive_bit(1'b0, int'(cpb));
        for (int i = 0; i < DB; i++) drive_bit(d[i], int'(cpb));
        if (pen) drive_bit(pbit, int'(cpb));
        drive_bit(stop, int'(cpb));
        drive_bit(1'b1, gap);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rx_ready = 1'b1;
        while (rx_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rx_ready = 1'b0;
        chk({name, "_valid_low"}, int'(rx_valid), 0);
        chk({name, "_all_popped"}, exp_q.size(), 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (rx_valid) vcount++;
            if (rx_valid && rx_ready) begin
                checks++;
                a_m = {rx_brk, rx_ferr, rx_perr, rx_data};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_entry got=%h", a_m);
                end else begin
                    e_m = exp_q.pop_front();
                    if (a_m !== e_m) begin
                        errors++;
                        $display("FAIL entry got={brk,ferr,perr,data}=%h exp=%h", a_m, e_m);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, gap;
        logic [7:0] d;
        bit pen, odd, pb, st;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_busy", int'(rx_busy), 0);
        chk("rst_ovr", int'(rx_overrun), 0);
        chk("rst_data", int'(rx_data), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        rx_ready = 1'b1;
        vcount = 0;
        send_frame(8'hA5, 0, 0, 0, 1, 1, 4);
        repeat (4) @(negedge clk);
        chk("valid_pulse_cycles", vcount, 1);

        send_frame(8'h03, 1, 0, 0, 1, 1, 2);
        send_frame(8'h03, 1, 0, 1, 1, 1, 2);
        send_frame(8'h55, 0, 0, 0, 0, 1, 2);

        parity_en = 1'b0;
        exp_q.push_back(model(8'h00, 0, 0, 0, 0));
        drive_bit(1'b0, 20 * int'(cpb));
        drive_bit(1'b1, 3 * int'(cpb));
        chk("break_single_entry", exp_q.size(), 0);

        rx = 1'b0;
        bc = 0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (rx_busy) bc++;
            if (i == 3) rx = 1'b1;
        end
        chk("glitch_busy_1to8", int'(bc >= 1 && bc <= 8), 1);
        chk("glitch_no_push", int'(rx_valid), 0);

        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(8'h11 * i), 0, 0, 0, 1, i < 5, 2);
        chk("ovr_set", int'(rx_overrun), 1);
        drain("ovr");
        chk("ovr_sticky", int'(rx_overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", int'(rx_overrun), 0);

        for (int i = 0; i < 4; i++) send_frame(8'(8'h61 + i), 0, 0, 0, 1, 1, 2);
        // pop exactly at the fifth frame's stop strobe (155th edge after the start fall)
        fork
            send_frame(8'h65, 0, 0, 0, 1, 1, 2);
            begin
                repeat (154) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        chk("coinc_no_ovr", int'(rx_overrun), 0);
        chk("coinc_valid", int'(rx_valid), 1);
        drain("coinc");

        send_frame(8'h81, 0, 0, 0, 1, 1, 2);
        send_frame(8'h82, 0, 0, 0, 1, 1, 2);
        d = 8'h5A;
        drive_bit(1'b0, int'(cpb));
        for (int i = 0; i < 3; i++) drive_bit(d[i], int'(cpb));
        drive_bit(d[3], int'(cpb) / 2);
        chk("mid_busy", int'(rx_busy), 1);
        chk("mid_valid", int'(rx_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(rx_valid), 0);
        chk("arst_busy", int'(rx_busy), 0);
        chk("arst_data", int'(rx_data), 0);
        exp_q.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        send_frame(8'hC3, 0, 0, 0, 1, 1, 4);
        repeat (4) @(negedge clk);
        chk("post_rst_frame", exp_q.size(), 0);

        rnd_ready = 1'b1;
        repeat (30) begin
            cpb = 16'($urandom_range(6, 24));
            d   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            st  = $urandom_range(0, 4) != 0;
            gap = $urandom_range(st ? 0 : 1, 3);
            send_frame(d, pen, odd, pb, st, 1, gap);
        end
        rnd_ready = 1'b0;
        drain("rand");
        chk("rand_no_ovr", int'(rx_overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver replacing the fixed 8-bit receiver on the bus UART path. It synchronises the serial `rx` line and qualifies the start bit at mid-bit. It samples LSB-first data with optional parity and checks the stop bit. Each frame is pushed with error flags into a small FIFO, which the bus side drains through a valid/ready handshake.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flops in the `rx` synchroniser, ≥2.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `cpb` in 16: clocks per bit, legal ≥4; changed only while `rx_busy`=0.
- `parity_en` in 1: a parity bit follows the data bits.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even.
- `rx_data` out DATA_BITS: FIFO head data.
- `rx_perr` out 1: head frame parity error.
- `rx_ferr` out 1: head frame framing error (stop bit sampled low).
- `rx_brk` out 1: head frame is a break (all data bits 0, parity bit 0 if enabled, stop bit low).
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts the head entry when high together with `rx_valid`.
- `rx_busy` out 1: frame in progress (state ≠ IDLE).
- `rx_overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `ovr_clr` in 1: single-cycle pulse that clears `rx_overrun`.

## Operation
- **Synchroniser.** `rx` passes through SYNC_STAGES flops to give `rx_s`. `rx_s_d` is `rx_s` delayed by one flop. The synchroniser resets to 1.
- **Bit timer.** 16-bit `cnt`, zeroed on every state entry. A sample strobe fires when `cnt` == `half`−1 in START, or `cnt` == `cpb`−1 in every other non-IDLE state. `half` = `cpb`>>1. On the strobe, `cnt` returns to 0.
- **IDLE.** A falling edge (`rx_s_d`=1, `rx_s`=0) moves to START.
- **START.** At the strobe:
  - `rx_s`=1: glitch; return to IDLE, nothing pushed.
  - `rx_s`=0: go to DATA, bit index 0.
- **DATA.** At each strobe, shift `rx_s` into bit [index], LSB first. After bit DATA_BITS−1, go to PARITY if `parity_en`, otherwise STOP.
- **PARITY.** At the strobe, `perr` = XOR(data bits, sampled bit, `parity_odd`). Go to STOP.
- **STOP.** At the strobe:
  - `ferr` = !`rx_s`.
  - `brk` = `ferr` & all data bits 0 & (parity bit 0 or parity disabled).
  - Push {`brk`, `ferr`, `perr`, data` into the FIFO and return to IDLE in the same cycle. The next start edge can be detected from the following cycle. A second stop bit is not checked.
- `perr` is 0 when `parity_en`=0.
- **FIFO.** Show-ahead; the head is presented combinationally from storage. Pop happens on `rx_valid & rx_ready`.
- **Push while full.**
  - With a pop in the same cycle: push accepted, count unchanged, no overrun.
  - Without a pop: frame dropped and `rx_overrun` set.
  - If a drop and `ovr_clr` occur in the same cycle, set wins.
- Read and write pointers carry one wrap bit, log2(FIFO_DEPTH)+1 wide. Full means MSBs differ and the rest are equal.
- **Reset values.** All outputs and state are 0 and state is IDLE, except that synchroniser flops are 1. `rx_data`/flags read 0 when empty. Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- `rx` fall to `rx_s` fall: SYNC_STAGES cycles. One further cycle to enter START.
- Start qualification sample: `half` cycles after START entry. Each later sample: `cpb` cycles after the previous one, which is mid-bit.
- Stop-bit strobe at cycle T: entry written at the T edge. `rx_valid` rises at T+1 when the FIFO was empty. `rx_busy` falls at T+1.
- Pop at edge T: the next entry, or `rx_valid`=0, is visible at T+1.
- Throughput: back-to-back frames with a single stop bit are received with no lost cycles.

## Test plan
- **8N1 frame.** `cpb`=16, DATA_BITS=8, frame 0xA5 driven at 16 clk/bit, `rx_ready`=1 → one entry with `rx_data`=0xA5 and `rx_perr`/`rx_ferr`/`rx_brk`=0. `rx_valid` is high for exactly 1 cycle, at stop-strobe+1.
- **Parity.** `parity_en`=1, `parity_odd`=0, data 0x03:
  - Parity bit 0 → `rx_perr`=0.
  - Parity bit 1 → `rx_perr`=1, `rx_data`=0x03.
- **Framing and break.**
  - 0x55 with stop bit driven low → `rx_ferr`=1, `rx_brk`=0.
  - `rx` held low for 20 bit times → first entry 0x00 with `rx_ferr`=1 and `rx_brk`=1. No further entry until `rx` returns high and falls again.
- **Glitch rejection.** `cpb`=16, `rx` low for 4 cycles → START entered, returns to IDLE, no push. `rx_busy` high for ≤8 cycles.
- **Overrun.** FIFO_DEPTH=4, `rx_ready`=0, frames 0x11, 0x22, 0x33, 0x44, 0x55 → `rx_overrun`=1 after the fifth frame. Popping then yields 0x11..0x44 in order, then `rx_valid`=0. `ovr_clr` clears the flag. A push coincident with a pop while full stores the frame without overrun.
- **Reset mid-frame.** `rst` asserted during data bit 3 with 2 entries queued → outputs 0 immediately (asynchronous), FIFO empty. A full frame 0xC3 after release is received correctly.
